pio_sequencer: RTL and testbench
================================

# pio_sequencer

Configuration sequencer for the 4-machine PIO block. On a single launch request it drives the PIO configuration port (mindex/din/index/action) through a fixed sequence: stop the target machine, copy a program from an external 16-bit program source into PIO instruction memory, set the wrap end, set the clock divider, then re-enable. It is the only writer of the PIO enable register and keeps a shadow of it, so launching one machine never disturbs the others.

## Interface
- NUM_SM, 4: number of state machines; widths of `sm` and `en_state` derive from it.
- IMEM_DEPTH, 32: PIO instruction memory depth; address width 5.
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  launch request; sampled only while busy=0
- sm  in  2  target machine index
- prog_base  in  5  first program-source address
- prog_len  in  6  instruction count, 0..32; 0 = no program load
- load_off  in  5  destination offset in PIO instruction memory
- clk_div  in  24  divider value for the target machine
- enable  in  1  1 = enable the machine at the end; 0 = leave it stopped
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse, sequence complete
- err  out  1  one-cycle pulse, request rejected
- en_state  out  4  enable shadow, the value last written with action 6
- rom_en  out  1  program-source read strobe
- rom_addr  out  5  program-source address
- rom_data  in  16  program-source data, valid 1 cycle after rom_en
- pio_mindex  out  2  to PIO `mindex`
- pio_index  out  5  to PIO `index`
- pio_din  out  32  to PIO `din`
- pio_action  out  4  to PIO `action`; 0 = no-op

## Operation
- States: IDLE, DISABLE, LOAD, PEND, DIV, ENABLE.
- IDLE, start=1: capture all request fields.
  - If load_off+prog_len > 32 (7-bit sum): pulse err, stay IDLE, issue no PIO action.
  - Otherwise go to DISABLE.
- DISABLE:
  - action=6, din={28'b0, en_shadow & ~(1<<sm)}; update en_shadow to the same value.
  - If prog_len≠0, also assert rom_en with rom_addr=prog_base.
- LOAD, pipelined:
  - Cycle k: action=1, index=load_off+k, din={16'b0, rom_data}.
  - rom_en/rom_addr=prog_base+k+1 while k+1<prog_len.
  - Source address wraps modulo 32.
  - Skipped when prog_len=0.
- PEND: action=2, mindex=sm, index=load_off+prog_len-1. Skipped when prog_len=0.
- DIV: action=7, mindex=sm, din={8'b0, clk_div}.
- ENABLE:
  - action=6, din={28'b0, en_shadow | (enable<<sm)}; update en_shadow to the same value.
  - Then return to IDLE and pulse done.
- Never issues actions 3, 4, 5, 8 or 9.
- start while busy=1 is ignored; no queuing.

## Timing
- All outputs registered. Reset values: all outputs 0, en_shadow 0, state IDLE.
- Start accepted at edge T0; first PIO action visible in cycle T0+1.
- prog_len=L>0:
  - DISABLE at T0+1; LOAD T0+2..T0+1+L; PEND T0+2+L; DIV T0+3+L; ENABLE T0+4+L.
  - done=1 and busy=0 at T0+5+L.
- L=0: DISABLE T0+1, DIV T0+2, ENABLE T0+3; done at T0+4.
- busy is 1 from T0+1 through the ENABLE cycle. err pulses at T0+1 with busy=0.
- A new start is accepted in the done cycle.
- pio_action returns to 0 in every cycle without an action.
- Reset mid-sequence aborts immediately (asynchronous). No resume; the PIO is reset alongside.

## Structure
- Shared package `pio_pkg`:
  - PIO action codes ACT_NONE=0, ACT_INSTR=1, ACT_PEND=2, ACT_PULL=3, ACT_PUSH=4, ACT_PINS=5, ACT_EN=6, ACT_DIV=7, ACT_SIDESET=8, ACT_IMM=9.
  - Sequencer state enum.
  - IMEM_DEPTH and NUM_SM constants.
- Single flat module; no sub-module.

## Test plan
- Reset, then sm=1, base=4, len=3, off=8, div=5, enable=1, ROM[4..6]=A,B,C:
  - action 6 din=0;
  - action 1 at index 8,9,10 with A,B,C;
  - action 2 index=10, mindex=1;
  - action 7 din=5;
  - action 6 din=0x2;
  - done at T0+8.
- After that, sm=0, len=0, enable=1:
  - action 6 din=0x2, action 7, action 6 din=0x3, done at T0+4;
  - no rom_en, no action 1 or 2.
- off=30, len=3: err pulse at T0+1, busy stays 0, pio_action stays 0, en_state unchanged.
- base=31, len=2: rom_addr sequence 31, 0 (source wrap).
- start re-asserted while busy: ignored, sequence completes unchanged.
- reset low in the middle of LOAD: all outputs 0 at once, en_state=0, then a new launch runs normally.
- sm=2 running (en_state=0x4), relaunch sm=2 with enable=0: final en_state=0x0; other bits never toggle during the sequence.

Source files
------------

// File: rtl/pio_pkg.sv
// Shared definitions for the PIO block: machine/memory sizes, configuration
// action codes and the sequencer state type.
package pio_pkg;

  localparam int NUM_SM     = 4;
  localparam int IMEM_DEPTH = 32;
  localparam int SM_W       = $clog2(NUM_SM);
  localparam int ADDR_W     = $clog2(IMEM_DEPTH);

  localparam logic [3:0] ACT_NONE    = 4'd0;
  localparam logic [3:0] ACT_INSTR   = 4'd1;
  localparam logic [3:0] ACT_PEND    = 4'd2;
  localparam logic [3:0] ACT_PULL    = 4'd3;
  localparam logic [3:0] ACT_PUSH    = 4'd4;
  localparam logic [3:0] ACT_PINS    = 4'd5;
  localparam logic [3:0] ACT_EN      = 4'd6;
  localparam logic [3:0] ACT_DIV     = 4'd7;
  localparam logic [3:0] ACT_SIDESET = 4'd8;
  localparam logic [3:0] ACT_IMM     = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DISABLE,
    ST_LOAD,
    ST_PEND,
    ST_DIV,
    ST_ENABLE
  } seq_state_t;

  // One-hot bit for a machine index within the enable register.
  function automatic logic [NUM_SM-1:0] sm_mask(input logic [SM_W-1:0] idx);
    return {{(NUM_SM-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/pio_sequencer_if.sv
// Program-source read port and PIO configuration port driven by the sequencer.
interface pio_sequencer_if;
  import pio_pkg::*;

  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic [SM_W-1:0]   pio_mindex;
  logic [ADDR_W-1:0] pio_index;
  logic [31:0]       pio_din;
  logic [3:0]        pio_action;

  modport master (
    output rom_en, rom_addr, pio_mindex, pio_index, pio_din, pio_action,
    input  rom_data
  );

  modport slave (
    input  rom_en, rom_addr, pio_mindex, pio_index, pio_din, pio_action,
    output rom_data
  );

endinterface

// File: rtl/pio_sequencer.sv
// Launch sequencer for one PIO machine: stop, copy program, set wrap and
// divider, re-enable. Sole owner of the PIO enable register (shadowed in en_state).
module pio_sequencer
  import pio_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [SM_W-1:0]   sm,
  input  logic [ADDR_W-1:0] prog_base,
  input  logic [ADDR_W:0]   prog_len,
  input  logic [ADDR_W-1:0] load_off,
  input  logic [23:0]       clk_div,
  input  logic              enable,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [NUM_SM-1:0] en_state,
  pio_sequencer_if.master   bus
);

  localparam logic [ADDR_W:0]   ONE_L = 1;
  localparam logic [ADDR_W-1:0] ONE_A = 1;
  localparam logic [ADDR_W+1:0] DEPTH_S = IMEM_DEPTH;

  seq_state_t        state_reg;
  logic [SM_W-1:0]   sm_reg;
  logic [ADDR_W-1:0] base_reg;
  logic [ADDR_W:0]   len_reg;
  logic [ADDR_W-1:0] off_reg;
  logic [23:0]       div_reg;
  logic              enable_reg;
  logic [ADDR_W:0]   k_reg;

  logic              busy_reg;
  logic              done_reg;
  logic              err_reg;
  logic [NUM_SM-1:0] en_state_reg;
  logic              rom_en_reg;
  logic [ADDR_W-1:0] rom_addr_reg;
  logic [SM_W-1:0]   mindex_reg;
  logic [ADDR_W-1:0] index_reg;
  logic [31:0]       din_reg;
  logic [3:0]        action_reg;
  logic              load_reg;

  logic [ADDR_W+1:0] fit_sum;
  logic [ADDR_W:0]   k_next;
  logic [NUM_SM-1:0] en_disable;
  logic [NUM_SM-1:0] en_enable;

  assign fit_sum    = {2'b00, load_off} + {1'b0, prog_len};
  assign k_next     = k_reg + ONE_L;
  assign en_disable = en_state_reg & ~sm_mask(sm);
  assign en_enable  = en_state_reg | (enable_reg ? sm_mask(sm_reg) : '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      sm_reg       <= '0;
      base_reg     <= '0;
      len_reg      <= '0;
      off_reg      <= '0;
      div_reg      <= '0;
      enable_reg   <= 1'b0;
      k_reg        <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      en_state_reg <= '0;
      rom_en_reg   <= 1'b0;
      rom_addr_reg <= '0;
      mindex_reg   <= '0;
      index_reg    <= '0;
      din_reg      <= '0;
      action_reg   <= ACT_NONE;
      load_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          busy_reg   <= 1'b0;
          rom_en_reg <= 1'b0;
          mindex_reg <= '0;
          index_reg  <= '0;
          din_reg    <= '0;
          action_reg <= ACT_NONE;
          load_reg   <= 1'b0;
          if (start) begin
            sm_reg     <= sm;
            base_reg   <= prog_base;
            len_reg    <= prog_len;
            off_reg    <= load_off;
            div_reg    <= clk_div;
            enable_reg <= enable;
            if (fit_sum > DEPTH_S) begin
              err_reg <= 1'b1;
            end else begin
              // Stop the target first; prefetch the first program word alongside.
              state_reg    <= ST_DISABLE;
              busy_reg     <= 1'b1;
              action_reg   <= ACT_EN;
              mindex_reg   <= sm;
              din_reg      <= {{(32-NUM_SM){1'b0}}, en_disable};
              en_state_reg <= en_disable;
              rom_en_reg   <= (prog_len != '0);
              rom_addr_reg <= prog_base;
            end
          end
        end

        ST_DISABLE: begin
          if (len_reg != '0) begin
            state_reg    <= ST_LOAD;
            k_reg        <= '0;
            action_reg   <= ACT_INSTR;
            index_reg    <= off_reg;
            din_reg      <= '0;
            load_reg     <= 1'b1;
            rom_en_reg   <= (len_reg > ONE_L);
            rom_addr_reg <= base_reg + ONE_A;
          end else begin
            state_reg  <= ST_DIV;
            action_reg <= ACT_DIV;
            index_reg  <= '0;
            din_reg    <= {8'b0, div_reg};
            rom_en_reg <= 1'b0;
          end
        end

        ST_LOAD: begin
          if (k_next < len_reg) begin
            k_reg        <= k_next;
            index_reg    <= off_reg + k_next[ADDR_W-1:0];
            rom_en_reg   <= ((k_next + ONE_L) < len_reg);
            rom_addr_reg <= base_reg + k_next[ADDR_W-1:0] + ONE_A;
          end else begin
            state_reg  <= ST_PEND;
            action_reg <= ACT_PEND;
            index_reg  <= off_reg + len_reg[ADDR_W-1:0] - ONE_A;
            load_reg   <= 1'b0;
            rom_en_reg <= 1'b0;
          end
        end

        ST_PEND: begin
          state_reg  <= ST_DIV;
          action_reg <= ACT_DIV;
          index_reg  <= '0;
          din_reg    <= {8'b0, div_reg};
        end

        ST_DIV: begin
          state_reg    <= ST_ENABLE;
          action_reg   <= ACT_EN;
          din_reg      <= {{(32-NUM_SM){1'b0}}, en_enable};
          en_state_reg <= en_enable;
        end

        ST_ENABLE: begin
          state_reg  <= ST_IDLE;
          busy_reg   <= 1'b0;
          done_reg   <= 1'b1;
          action_reg <= ACT_NONE;
          mindex_reg <= '0;
          din_reg    <= '0;
        end

        default: begin
          state_reg  <= ST_IDLE;
          busy_reg   <= 1'b0;
          action_reg <= ACT_NONE;
          rom_en_reg <= 1'b0;
          load_reg   <= 1'b0;
        end
      endcase
    end
  end

  // During LOAD the instruction word comes straight from the program source,
  // whose registered read lands in the same cycle it must be written.
  assign bus.pio_din    = load_reg ? {16'b0, bus.rom_data} : din_reg;
  assign bus.rom_en     = rom_en_reg;
  assign bus.rom_addr   = rom_addr_reg;
  assign bus.pio_mindex = mindex_reg;
  assign bus.pio_index  = index_reg;
  assign bus.pio_action = action_reg;

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign err      = err_reg;
  assign en_state = en_state_reg;

endmodule

// File: tb/tb_pio_sequencer.sv
// Randomized scoreboard bench for pio_sequencer: a transaction-level model
// queues expected PIO actions, ROM reads and completion events.
module tb_pio_sequencer;

  localparam int K_DONE = 16;
  localparam int K_ERR  = 17;

  typedef struct {
    int          kind;
    logic [1:0]  mindex;
    bit          chk_m;
    logic [4:0]  index;
    bit          chk_i;
    logic [31:0] din;
    bit          chk_d;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  sm;
  logic [4:0]  prog_base;
  logic [5:0]  prog_len;
  logic [4:0]  load_off;
  logic [23:0] clk_div;
  logic        enable;
  logic        busy;
  logic        done;
  logic        err;
  logic [3:0]  en_state;

  pio_sequencer_if bus();

  pio_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .sm        (sm),
    .prog_base (prog_base),
    .prog_len  (prog_len),
    .load_off  (load_off),
    .clk_div   (clk_div),
    .enable    (enable),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .en_state  (en_state),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [32];
  always @(posedge clk) if (bus.rom_en) bus.rom_data <= rom[bus.rom_addr];

  exp_t       exp_q [$];
  logic [4:0] rom_q [$];
  logic [3:0] model_en = 4'd0;
  logic [1:0] cur_sm   = 2'd0;
  logic [3:0] cur_pre  = 4'd0;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void push_exp(int k, logic [1:0] m, bit cm, logic [4:0] i, bit ci,
                                   logic [31:0] d, bit cd);
    exp_t e;
    e.kind = k; e.mindex = m; e.chk_m = cm; e.index = i; e.chk_i = ci; e.din = d; e.chk_d = cd;
    exp_q.push_back(e);
  endfunction

  // Reference: what one launch request must produce, in order.
  function automatic void model_req(logic [1:0] s, logic [4:0] b, logic [5:0] l,
                                    logic [4:0] o, logic [23:0] d, logic e);
    if (int'(o) + int'(l) > 32) begin
      push_exp(K_ERR, 2'd0, 0, 5'd0, 0, 32'd0, 0);
      return;
    end
    model_en = model_en & ~(4'b0001 << s);
    push_exp(6, s, 0, 5'd0, 0, {28'd0, model_en}, 1);
    for (int k = 0; k < int'(l); k++) begin
      rom_q.push_back(5'(int'(b) + k));
      push_exp(1, s, 0, 5'(int'(o) + k), 1, {16'd0, rom[5'(int'(b) + k)]}, 1);
    end
    if (l != 0) push_exp(2, s, 1, 5'(int'(o) + int'(l) - 1), 1, 32'd0, 0);
    push_exp(7, s, 1, 5'd0, 0, {8'd0, d}, 1);
    if (e) model_en = model_en | (4'b0001 << s);
    push_exp(6, s, 0, 5'd0, 0, {28'd0, model_en}, 1);
    push_exp(K_DONE, 2'd0, 0, 5'd0, 0, {28'd0, model_en}, 1);
  endfunction

  // Monitor: pops one expectation per observed DUT event.
  exp_t mon_e;
  int   obs;
  always @(negedge clk) begin
    if (reset) begin
      obs = 0;
      if (bus.pio_action != 4'd0) obs = int'(bus.pio_action);
      else if (done)             obs = K_DONE;
      else if (err)              obs = K_ERR;
      if (obs != 0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", obs, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("event_kind", obs, mon_e.kind);
          if (mon_e.chk_m) chk("mindex", bus.pio_mindex, mon_e.mindex);
          if (mon_e.chk_i) chk("index", bus.pio_index, mon_e.index);
          if (mon_e.chk_d && obs == K_DONE) chk("done_en_state", en_state, mon_e.din);
          else if (mon_e.chk_d) chk("din", bus.pio_din, mon_e.din);
          if (obs == K_ERR) chk("err_busy", busy, 0);
        end
      end
      if (bus.rom_en) begin
        if (rom_q.size() == 0) chk("unexpected_rom_en", bus.rom_en, 0);
        else chk("rom_addr", bus.rom_addr, rom_q.pop_front());
      end
      if (busy) chk("other_en_bits", (en_state ^ cur_pre) & ~(4'b0001 << cur_sm), 0);
    end
  end

  task automatic run_req(input logic [1:0] s, input logic [4:0] b, input logic [5:0] l,
                         input logic [4:0] o, input logic [23:0] d, input logic e, input bit poke);
    int cyc;
    bit bad;
    logic [3:0] en_before;
    bad = (int'(o) + int'(l) > 32);
    en_before = model_en;
    cur_sm = s;
    cur_pre = model_en;
    model_req(s, b, l, o, d, e);
    @(posedge clk); #1;
    sm = s; prog_base = b; prog_len = l; load_off = o; clk_div = d; enable = e; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (bad) begin
      chk("err_pulse", err, 1);
      chk("err_busy_low", busy, 0);
      chk("err_no_action", bus.pio_action, 0);
      @(posedge clk); #1;
      chk("err_busy_stays_low", busy, 0);
      chk("err_en_state", en_state, en_before);
      $display("req sm=%0d base=%0d len=%0d off=%0d en=%0d -> rejected en_state=%h",
               s, b, l, o, e, en_state);
    end else begin
      chk("first_action_t1", bus.pio_action, 6);
      chk("busy_t1", busy, 1);
      cyc = 1;
      while (!done && cyc < 200) begin
        if (poke && cyc == 2) begin
          start = 1'b1; sm = ~s; prog_len = 6'd1; load_off = 5'd0; enable = ~e;
        end
        if (poke && cyc == 3) start = 1'b0;
        @(posedge clk); #1;
        cyc++;
      end
      start = 1'b0;
      chk("done_latency", cyc, (l == 0) ? 4 : 5 + int'(l));
      chk("busy_low_at_done", busy, 0);
      $display("req sm=%0d base=%0d len=%0d off=%0d div=%0d en=%0d poke=%0d -> done after %0d cycles en_state=%h",
               s, b, l, o, d, e, poke, cyc, en_state);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 16'($urandom);
    reset = 1'b0; start = 1'b0; sm = '0; prog_base = '0; prog_len = '0;
    load_off = '0; clk_div = '0; enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    chk("reset_en_state", en_state, 0);
    chk("reset_action", bus.pio_action, 0);
    chk("reset_rom_en", bus.rom_en, 0);
    reset = 1'b1;

    run_req(2'd1, 5'd4, 6'd3, 5'd8, 24'd5, 1'b1, 0);
    run_req(2'd0, 5'd9, 6'd0, 5'd3, 24'h00abcd, 1'b1, 0);
    run_req(2'd3, 5'd0, 6'd3, 5'd30, 24'd7, 1'b1, 0);
    run_req(2'd2, 5'd31, 6'd2, 5'd0, 24'd9, 1'b0, 0);
    run_req(2'd1, 5'd12, 6'd4, 5'd2, 24'h123456, 1'b1, 1);
    run_req(2'd3, 5'd20, 6'd0, 5'd0, 24'd1, 1'b1, 1);
    run_req(2'd0, 5'd0, 6'd32, 5'd0, 24'd3, 1'b1, 0);

    // Abort a sequence in the middle of LOAD with an asynchronous reset.
    cur_sm = 2'd1;
    cur_pre = model_en;
    model_req(2'd1, 5'd0, 6'd10, 5'd0, 24'd2, 1'b1);
    @(posedge clk); #1;
    sm = 2'd1; prog_base = 5'd0; prog_len = 6'd10; load_off = 5'd0; clk_div = 24'd2; enable = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    chk("in_load_before_reset", bus.pio_action, 1);
    reset = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_action", bus.pio_action, 0);
    chk("abort_din", bus.pio_din, 0);
    chk("abort_index", bus.pio_index, 0);
    chk("abort_rom_en", bus.rom_en, 0);
    chk("abort_en_state", en_state, 0);
    exp_q.delete();
    rom_q.delete();
    model_en = 4'd0;
    $display("reset asserted mid-LOAD -> outputs cleared en_state=%h", en_state);
    @(posedge clk); #1;
    reset = 1'b1;

    run_req(2'd2, 5'd5, 6'd2, 5'd4, 24'd11, 1'b1, 0);
    run_req(2'd2, 5'd6, 6'd1, 5'd7, 24'd12, 1'b0, 0);
    chk("sm2_disabled", en_state, 0);

    for (int n = 0; n < 24; n++) begin
      run_req(2'($urandom_range(0, 3)), 5'($urandom), 6'($urandom_range(0, 32)),
              5'($urandom), 24'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("rom_reads_drained", rom_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
